// File: rtl/pc_sequencer.sv
// Next-PC controller for the MIPS32 fetch stage: owns the word-addressed PC and the fetch request.
// Optional macro PC_SEQ_DELAY_SLOT_EN: redirects take effect after one architectural delay slot.
module pc_sequencer #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     inst,
  input  logic            inst_valid,
  input  logic            jump,
  input  logic            branch,
  input  logic            br_taken,
  input  logic            jr,
  input  logic [PC_W-1:0] jr_addr,
  input  logic            stall,
  input  logic            im_ack,
  output logic [PC_W-1:0] pc,
  output logic            im_req,
  output logic            flush,
  output logic [1:0]      state
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [PC_W-1:0] pc_reg, pc_next;
  logic [PC_W-1:0] target_reg, target_next;
  logic            pend_reg, pend_next;
  logic            flush_reg, flush_next;
`ifdef PC_SEQ_DELAY_SLOT_EN
  logic            slot_reg, slot_next;
`endif

  logic            redirect_req;
  logic            capture;
  logic            accept;
  logic            eff_pend;
  logic [PC_W-1:0] eff_target;
  logic [PC_W-1:0] seq_pc;
  logic [PC_W-1:0] new_target;
  logic [PC_W-1:0] br_offset;

  // The opcode field is not needed here; decode has already classified it.
  logic unused_inst_hi;
  assign unused_inst_hi = &{1'b0, inst[31:26]};

  assign redirect_req = inst_valid & (jr | jump | (branch & br_taken));
  assign seq_pc       = pc_reg + PC_W'(1);
  assign br_offset    = {{(PC_W-16){inst[15]}}, inst[15:0]};

  always_comb begin
    if (jr)
      new_target = jr_addr;
    else if (jump)
      new_target = {pc_reg[PC_W-1:PC_W-6], inst[25:0]};
    else
      new_target = seq_pc + br_offset;
  end

  // First request wins; later ones are wrong-path and dropped while one is pending.
  assign capture    = redirect_req & ~pend_reg & (state_reg != ST_BOOT);
  assign eff_pend   = pend_reg | capture;
  assign eff_target = pend_reg ? target_reg : new_target;
  assign accept     = (state_reg == ST_FETCH) & im_ack & ~stall;

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    target_next = target_reg;
    pend_next   = pend_reg;
    flush_next  = 1'b0;
`ifdef PC_SEQ_DELAY_SLOT_EN
    slot_next   = slot_reg;
`endif

    case (state_reg)
      ST_BOOT:  state_next = ST_FETCH;
      ST_FETCH: if (stall) state_next = ST_HOLD;
      ST_HOLD:  if (!stall) state_next = ST_FETCH;
      default:  state_next = ST_BOOT;
    endcase

    if (capture) begin
      pend_next   = 1'b1;
      target_next = new_target;
    end

`ifdef PC_SEQ_DELAY_SLOT_EN
    // The first accepted fetch after a request is the delay slot and stays sequential.
    if (accept) begin
      if (eff_pend && slot_reg) begin
        pc_next   = target_reg;
        pend_next = 1'b0;
        slot_next = 1'b0;
      end else begin
        pc_next   = seq_pc;
        slot_next = eff_pend;
      end
    end
`else
    if (accept) begin
      if (eff_pend) begin
        pc_next    = eff_target;
        pend_next  = 1'b0;
        flush_next = 1'b1;
      end else begin
        pc_next = seq_pc;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_BOOT;
      pc_reg     <= RESET_PC;
      target_reg <= '0;
      pend_reg   <= 1'b0;
      flush_reg  <= 1'b0;
`ifdef PC_SEQ_DELAY_SLOT_EN
      slot_reg   <= 1'b0;
`endif
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      target_reg <= target_next;
      pend_reg   <= pend_next;
      flush_reg  <= flush_next;
`ifdef PC_SEQ_DELAY_SLOT_EN
      slot_reg   <= slot_next;
`endif
    end
  end

  assign pc     = pc_reg;
  assign im_req = (state_reg == ST_FETCH);
  assign flush  = flush_reg;
  assign state  = state_reg;

endmodule
